// File: rtl/qam_mapper_if.sv
// Wishbone-style streaming handshake bundle shared by the mapper's
// input (coded bits) and output (mapped symbols) sides.
interface qam_mapper_if;
    logic [31:0] dat;
    logic        cyc;
    logic        stb;
    logic        we;
    logic        ack;

    modport master (output dat, output cyc, output stb, output we, input ack);
    modport slave  (input dat, input cyc, input stb, input we, output ack);
endinterface

// File: rtl/qam_mapper.sv
// Streaming constellation mapper: 32-bit bit words in, one complex
// data-carrier symbol {Im[31:16], Re[15:0]} (Q1.15) out per beat.
// One CYC frame carries one OFDM symbol; a residual partial group at
// frame end is zero-padded and emitted as a final symbol.
module qam_mapper #(
    parameter logic [15:0] L_QPSK = 16'h5A82,
    parameter logic [15:0] L16_1  = 16'h2AAA,
    parameter logic [15:0] L16_3  = 16'h7FFE,
    parameter logic [15:0] L64_1  = 16'h1249,
    parameter logic [15:0] L64_3  = 16'h36DB,
    parameter logic [15:0] L64_5  = 16'h5B6D,
    parameter logic [15:0] L64_7  = 16'h7FFF
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [1:0]    MOD_I,
    qam_mapper_if.slave   up,
    qam_mapper_if.master  dn
);
    localparam logic [1:0]  MOD_BPSK = 2'b00;
    localparam logic [1:0]  MOD_QPSK = 2'b01;
    localparam logic [1:0]  MOD_16   = 2'b10;
    localparam logic [1:0]  MOD_64   = 2'b11;
    localparam logic [15:0] L_BPSK   = 16'h7FFF;

    logic [37:0] bit_buf_q;
    logic [5:0]  cnt_q;
    logic [1:0]  mode_q;
    logic        flush_q;
    logic        ended_q;
    logic        cyc_q;
    logic        stb_q;
    logic [31:0] dat_q;

    logic [5:0]  bps;
    logic [5:0]  grp;
    logic        have_full;
    logic        pad;
    logic        out_free;
    logic        gen;
    logic        load;
    logic        frame_over;
    logic        flush_set;
    logic        cyc_clear;
    logic [15:0] sym_i;
    logic [15:0] sym_q;

    // Axis level: s is the sign bit (earliest), m1/m2 select the magnitude (Gray order).
    function automatic logic [15:0] level(input logic [1:0] mode, input logic s,
                                          input logic m1, input logic m2);
        logic [15:0] mag;
        case (mode)
            MOD_BPSK: mag = L_BPSK;
            MOD_QPSK: mag = L_QPSK;
            MOD_16:   mag = m1 ? L16_1 : L16_3;
            default: begin
                case ({m1, m2})
                    2'b00:   mag = L64_7;
                    2'b01:   mag = L64_5;
                    2'b11:   mag = L64_3;
                    default: mag = L64_1;
                endcase
            end
        endcase
        return s ? mag : 16'(~mag + 16'd1);
    endfunction

    // Handshake decisions, frame bookkeeping and symbol mapping for this cycle.
    always_comb begin
        case (mode_q)
            MOD_BPSK: bps = 6'd1;
            MOD_QPSK: bps = 6'd2;
            MOD_16:   bps = 6'd4;
            default:  bps = 6'd6;
        endcase
        grp        = bit_buf_q[5:0];
        have_full  = (cnt_q >= bps);
        pad        = flush_q & (cnt_q != 6'd0);
        out_free   = ~stb_q | dn.ack;
        gen        = (have_full | pad) & out_free;
        load       = RST_I & up.cyc & up.stb & up.we & (cnt_q < bps) & ~flush_q & ~ended_q;
        // ended_q covers a CYC_I that rose again while the old frame still drains
        frame_over = ~up.cyc | ended_q;
        flush_set  = cyc_q & frame_over & (cnt_q != 6'd0) & ~have_full;
        cyc_clear  = cyc_q & frame_over & (cnt_q == 6'd0) & out_free;
        sym_i      = level(mode_q, grp[0], grp[1], grp[2]);
        case (mode_q)
            MOD_BPSK: sym_q = '0;
            MOD_QPSK: sym_q = level(mode_q, grp[1], 1'b0, 1'b0);
            MOD_16:   sym_q = level(mode_q, grp[2], grp[3], 1'b0);
            default:  sym_q = level(mode_q, grp[3], grp[4], grp[5]);
        endcase
    end

    assign up.ack = load;
    assign dn.dat = dat_q;
    assign dn.cyc = cyc_q;
    assign dn.stb = stb_q;
    assign dn.we  = stb_q;

    // Bit buffer, output register and frame state.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            bit_buf_q <= '0;
            cnt_q     <= '0;
            mode_q    <= MOD_QPSK;
            flush_q   <= 1'b0;
            ended_q   <= 1'b0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            if (load) begin
                bit_buf_q <= bit_buf_q | (38'(up.dat) << cnt_q);
                cnt_q     <= cnt_q + 6'd32;
            end else if (gen) begin
                // bits above cnt_q are always zero, so a padded group needs no masking
                bit_buf_q <= bit_buf_q >> bps;
                cnt_q     <= have_full ? (cnt_q - bps) : '0;
            end

            if (gen) begin
                dat_q <= {sym_q, sym_i};
                stb_q <= 1'b1;
            end else if (dn.ack) begin
                stb_q <= 1'b0;
            end

            if (up.cyc && !cyc_q) begin
                cyc_q  <= 1'b1;
                mode_q <= MOD_I;
            end else if (cyc_clear) begin
                cyc_q  <= 1'b0;
            end

            if (cyc_clear)
                ended_q <= 1'b0;
            else if (cyc_q && !up.cyc)
                ended_q <= 1'b1;

            if (cyc_clear)
                flush_q <= 1'b0;
            else if (flush_set)
                flush_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: hand-computed symbol vectors per modulation,
// back-pressure hold, frame-end flush and asynchronous reset.
module tb_qam_mapper;
    logic        clk;
    logic        rst_n;
    logic [1:0]  mod;
    int          n_checks;
    int          n_err;
    int          waited;
    int          bad;
    logic [31:0] beats[$];

    qam_mapper_if up_if();
    qam_mapper_if dn_if();

    qam_mapper dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .MOD_I (mod),
        .up    (up_if),
        .dn    (dn_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every output beat that the downstream side accepts at the next edge.
    always @(negedge clk) begin
        if (rst_n && dn_if.stb && dn_if.ack)
            beats.push_back(dn_if.dat);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_word(input logic [31:0] w, output int low_cycles);
        up_if.dat = w;
        up_if.stb = 1'b1;
        up_if.we  = 1'b1;
        low_cycles = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (up_if.ack) break;
            low_cycles++;
        end
        check_val("word accepted", {31'd0, up_if.ack}, 32'd1);
        step();
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
    endtask

    task automatic wait_beats(input int n, input string tag);
        for (int i = 0; i < 1000 && beats.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check_val(tag, {31'd0, beats.size() >= n}, 32'd1);
    endtask

    task automatic end_frame(input string tag);
        up_if.cyc = 1'b0;
        for (int i = 0; i < 1000 && dn_if.cyc; i++) begin
            @(negedge clk);
            #1;
        end
        check_val(tag, {31'd0, dn_if.cyc}, 32'd0);
        step();
    endtask

    task automatic count_tail(input int from, input logic [31:0] exp, output int mism);
        mism = 0;
        for (int i = from; i < beats.size(); i++)
            if (beats[i] !== exp) mism++;
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        mod       = 2'b01;
        up_if.cyc = 1'b1;
        up_if.stb = 1'b1;
        up_if.we  = 1'b1;
        up_if.dat = 32'hFFFF_FFFF;
        dn_if.ack = 1'b1;
        #12;
        check_val("reset DAT_O", dn_if.dat, 32'h0);
        check_val("reset CYC_O", {31'd0, dn_if.cyc}, 32'd0);
        check_val("reset STB_O", {31'd0, dn_if.stb}, 32'd0);
        check_val("reset WE_O",  {31'd0, dn_if.we},  32'd0);
        check_val("reset ACK_O", {31'd0, up_if.ack}, 32'd0);
        up_if.cyc = 1'b0;
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        // QPSK: one word of 1 then a word of 0
        beats.delete();
        mod = 2'b01;
        up_if.cyc = 1'b1;
        put_word(32'h0000_0001, waited);
        put_word(32'h0000_0000, waited);
        check_val("qpsk ack low cycles", waited, 32'd16);
        end_frame("qpsk cyc_o fall");
        check_val("qpsk beat count", beats.size(), 32'd32);
        check_val("qpsk first", beats[0], 32'hA57E_5A82);
        count_tail(1, 32'hA57E_A57E, bad);
        check_val("qpsk tail", bad, 32'd0);

        // 16QAM with MOD_I changed mid-frame (must be ignored)
        beats.delete();
        mod = 2'b10;
        up_if.cyc = 1'b1;
        put_word(32'h0000_000B, waited);
        mod = 2'b00;
        end_frame("16qam cyc_o fall");
        check_val("16qam beat count", beats.size(), 32'd8);
        check_val("16qam first", beats[0], 32'hD556_2AAA);
        count_tail(1, 32'h8002_8002, bad);
        check_val("16qam tail", bad, 32'd0);

        // 64QAM: residual 2 bits join the next word, then flush of 4 bits
        beats.delete();
        mod = 2'b11;
        up_if.cyc = 1'b1;
        put_word(32'h0000_0004, waited);
        put_word(32'h0000_000D, waited);
        check_val("64qam ack low cycles", waited, 32'd5);
        end_frame("64qam cyc_o fall");
        check_val("64qam beat count", beats.size(), 32'd11);
        check_val("64qam first", beats[0], 32'h8001_A493);
        check_val("64qam straddle", beats[5], 32'hC925_A493);
        check_val("64qam padded", beats[10], 32'h8001_8001);

        // 64QAM single word, CYC_I dropped: 5 symbols + padded 6th
        beats.delete();
        up_if.cyc = 1'b1;
        put_word(32'hFFFF_FFFF, waited);
        up_if.cyc = 1'b0;
        wait_beats(6, "64qam flush beats");
        check_val("flush cyc_o before last ack", {31'd0, dn_if.cyc}, 32'd1);
        check_val("flush first", beats[0], 32'h36DB_36DB);
        check_val("flush padded", beats[5], 32'h8001_1249);
        step();
        check_val("flush cyc_o after last ack", {31'd0, dn_if.cyc}, 32'd0);
        check_val("flush stb_o after last ack", {31'd0, dn_if.stb}, 32'd0);
        repeat (5) step();
        check_val("flush beat count", beats.size(), 32'd6);

        // BPSK with 10-cycle downstream stall
        beats.delete();
        mod = 2'b00;
        up_if.cyc = 1'b1;
        put_word(32'hFFFF_FFFF, waited);
        up_if.cyc = 1'b0;
        wait_beats(5, "bpsk pre-stall beats");
        step();
        dn_if.ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check_val("bpsk hold dat", dn_if.dat, 32'h0000_7FFF);
            check_val("bpsk hold stb", {31'd0, dn_if.stb}, 32'd1);
        end
        step();
        dn_if.ack = 1'b1;
        end_frame("bpsk cyc_o fall");
        check_val("bpsk beat count", beats.size(), 32'd32);
        count_tail(0, 32'h0000_7FFF, bad);
        check_val("bpsk beats", bad, 32'd0);

        // Reset mid-frame, then a QPSK frame
        beats.delete();
        mod = 2'b10;
        up_if.cyc = 1'b1;
        put_word(32'hFFFF_FFFF, waited);
        wait_beats(2, "pre-reset beats");
        up_if.stb = 1'b1;
        up_if.we  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async reset DAT_O", dn_if.dat, 32'h0);
        check_val("async reset CYC_O", {31'd0, dn_if.cyc}, 32'd0);
        check_val("async reset STB_O", {31'd0, dn_if.stb}, 32'd0);
        check_val("async reset ACK_O", {31'd0, up_if.ack}, 32'd0);
        up_if.cyc = 1'b0;
        up_if.stb = 1'b0;
        up_if.we  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        beats.delete();
        mod = 2'b01;
        up_if.cyc = 1'b1;
        put_word(32'h0000_0002, waited);
        end_frame("post-reset cyc_o fall");
        check_val("post-reset beat count", beats.size(), 32'd16);
        check_val("post-reset first", beats[0], 32'h5A82_A57E);
        count_tail(1, 32'hA57E_A57E, bad);
        check_val("post-reset tail", bad, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Streaming constellation mapper placed directly upstream of the pilot-insertion stage.
- Takes 32-bit words of coded or interleaved bits and emits one complex data-carrier symbol per output beat.
- Output format is 32-bit {Im[31:16], Re[15:0]}, Q1.15.
- Uses the same Wishbone-style streaming handshake (CYC/STB/WE/ACK) on both sides. One CYC frame carries the data of one OFDM symbol.

Parameters:
- L_QPSK, 16'h5A82, QPSK axis magnitude.
- L16_1, 16'h2AAA, 16QAM inner magnitude.
- L16_3, 16'h7FFE, 16QAM outer magnitude.
- L64_1 / L64_3 / L64_5 / L64_7, 16'h1249 / 16'h36DB / 16'h5B6D / 16'h7FFF, 64QAM magnitudes.

Ports:
- CLK_I, in, 1, clock; all flops on the rising edge.
- RST_I, in, 1, reset; asynchronous, active-low.
- MOD_I, in, 2, modulation select: 00 BPSK, 01 QPSK, 10 16QAM, 11 64QAM.
- DAT_I, in, 32, input bits; DAT_I[0] is the first bit in time.
- CYC_I, in, 1, input frame valid.
- STB_I, in, 1, input strobe.
- WE_I, in, 1, input write.
- ACK_O, out, 1, input word accepted this cycle.
- DAT_O, out, 32, mapped symbol {Im, Re}.
- CYC_O, out, 1, output frame valid.
- STB_O, out, 1, output symbol valid.
- WE_O, out, 1, equals STB_O.
- ACK_I, in, 1, downstream accepts DAT_O.

Behaviour:
- Reset (RST_I low, asynchronous): DAT_O=0, CYC_O=0, STB_O=0, bit buffer cleared, count=0, mode register=01, flush flag=0. ACK_O=0 while in reset.
- Bits per symbol (bps):
  - BPSK 1, QPSK 2, 16QAM 4, 64QAM 6.
  - MOD_I is latched on the first cycle with CYC_I=1 after CYC_I=0, and held for the whole frame.
- Bit buffer:
  - 38-bit register with a 6-bit count; bit 0 is the oldest bit.
  - Load: buf |= DAT_I << count; count += 32.
  - Consume: buf >>= bps; count -= bps.
- Input accept: ACK_O = CYC_I & STB_I & WE_I & (count < bps) & ~flush. This is combinational. The word is loaded at the same edge.
- Symbol generate:
  - Condition: (count >= bps) & (~STB_O | ACK_I).
  - On generate, DAT_O is loaded and STB_O is set at the edge.
  - Load and consume are mutually exclusive by construction.
- Latency: a word accepted at edge k makes its first symbol valid on DAT_O/STB_O after edge k+1.
- Output hold:
  - STB_O & ~ACK_I holds DAT_O and STB_O and stalls generation.
  - STB_O clears at an edge where ACK_I=1 and no new symbol is generated.
- Axis mapping:
  - First half of the bit group maps to I, second half to Q. b0 is the earliest bit.
  - Negative levels are the two's complement of the magnitude.
  - BPSK: b0 0→-0x7FFF, 1→+0x7FFF; Q=0.
  - QPSK: b 0→-L_QPSK, 1→+L_QPSK.
  - 16QAM (b0b1): 00→-3, 01→-1, 11→+1, 10→+3.
  - 64QAM (b0b1b2): 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Frame control:
  - CYC_O sets at the edge after the first CYC_I=1 cycle.
  - When CYC_I falls with 0 < count < bps, flush is set. The residual bits are zero-padded to a full group and emitted as one final symbol, and count becomes 0.
  - CYC_O clears at the edge where CYC_I=0, count=0, and STB_O is not pending (or is being acked).
  - Flush clears together with CYC_O.
- A CYC_I rise while CYC_O is still high (previous frame draining) is not a new frame until CYC_O has cleared. ACK_O stays 0 in that window.
- Reset mid-frame: all state cleared immediately; a partial symbol is never emitted.

Test Plan:
- QPSK, DAT_I=32'h00000001 in one word, ACK_I=1 → DAT_O=32'hA57E5A82 (I=+, Q=-), then 15 beats of 32'hA57EA57E. ACK_O deasserts for 16 cycles.
- 16QAM, DAT_I=32'h0000000B → first DAT_O=32'hD5562AAA; the remaining 7 symbols are 32'h80028002.
- 64QAM, DAT_I=32'h00000004 → first DAT_O=32'h8001A493. After 5 symbols, 2 bits remain and the next word is accepted.
- 64QAM frame of one word with CYC_I dropped → 5 symbols plus a 6th zero-padded symbol. CYC_O falls after the 6th ACK_I.
- BPSK, DAT_I=32'hFFFFFFFF, ACK_I low for 10 cycles mid-stream → DAT_O holds 32'h00007FFF stable. Exactly 32 beats total, none lost or duplicated.
- RST_I pulsed low mid-frame → all outputs are 0 asynchronously. The next frame's first symbol is correct for the newly latched MOD_I.
